// File: rtl/seg7_serial_rx.sv
// Receiver for the four-wire serial seven-segment link: oversamples the pins,
// deserialises each frame and decodes every digit back to hex plus decimal point.
module seg7_serial_rx #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  seg_clk,
    input  logic                  seg_do,
    input  logic                  seg_pen,
    input  logic                  seg_clr,
    output logic [8*DIGITS-1:0]   frame,
    output logic [4*DIGITS-1:0]   data,
    output logic [DIGITS-1:0]     point,
    output logic                  frame_valid,
    output logic                  len_err,
    output logic                  dec_err
);

    localparam int unsigned FRAME_W = 8 * DIGITS;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned PIN_W   = 4;
    // Sync bit order {clr, pen, do, clk}; clr idles high.
    localparam logic [PIN_W-1:0] PIN_RST = 4'b1000;

    logic [PIN_W-1:0]   r_sync1;
    logic [PIN_W-1:0]   r_sync2;
    logic [1:0]         r_hist;
    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_clk_rise;
    logic               w_pen_rise;
    logic               w_clr_act;
    logic               w_do;
    logic [FRAME_W-1:0] w_sr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [4*DIGITS-1:0] w_data;
    logic [DIGITS-1:0]  w_point;
    logic               w_dec_err;
    logic [7:0]         w_byte;
    logic [4:0]         w_dig;

    // Returns {valid, nibble}; patterns are active-low {g,f,e,d,c,b,a}.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    assign w_clk_rise = r_sync2[0] & ~r_hist[0];
    assign w_pen_rise = r_sync2[2] & ~r_hist[1];
    assign w_do       = r_sync2[1];
    assign w_clr_act  = ~r_sync2[3];

    // Shift/clear update; the latch below sees this post-update value.
    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
        if (w_clr_act) begin
            w_sr_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (w_clk_rise) begin
            w_sr_nxt  = {r_sr[FRAME_W-2:0], w_do};
            w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 7'd1;
        end
    end

    // Per-digit decode of the image about to be latched.
    always_comb begin
        w_data    = '0;
        w_point   = '0;
        w_dec_err = 1'b0;
        w_byte    = '0;
        w_dig     = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            w_byte            = w_sr_nxt[8*d +: 8];
            w_dig             = seg_decode(w_byte[6:0]);
            w_data[4*d +: 4]  = w_dig[3:0];
            w_point[d]        = ~w_byte[7];
            w_dec_err         = w_dec_err | ~w_dig[4];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1     <= PIN_RST;
            r_sync2     <= PIN_RST;
            r_hist      <= '0;
            r_sr        <= '0;
            r_cnt       <= '0;
            frame       <= '0;
            data        <= '0;
            point       <= '0;
            frame_valid <= 1'b0;
            len_err     <= 1'b0;
            dec_err     <= 1'b0;
        end else begin
            r_sync1     <= {seg_clr, seg_pen, seg_do, seg_clk};
            r_sync2     <= r_sync1;
            r_hist      <= {r_sync2[2], r_sync2[0]};
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_pen_rise ? '0 : w_cnt_nxt;
            frame_valid <= w_pen_rise;
            if (w_pen_rise) begin
                frame   <= w_sr_nxt;
                data    <= w_data;
                point   <= w_point;
                len_err <= (w_cnt_nxt != 7'(FRAME_W));
                dec_err <= w_dec_err;
            end
        end
    end

endmodule
